// File: rtl/id_operand_stage_pkg.sv
// Shared definitions for the ID operand stage: stall-cause encodings and
// the jal link offset.
package id_operand_stage_pkg;

  typedef enum logic [1:0] {
    CAUSE_RUN      = 2'd0,
    CAUSE_LU_STALL = 2'd1,
    CAUSE_MEM_WAIT = 2'd2
  } cause_e;

  // jal writes the return address past the delay slot
  localparam int unsigned LINK_OFFSET = 8;

endpackage

// File: rtl/id_operand_stage_if.sv
// Bundle of the ID, EX, MEM and WB pipeline signals seen by the operand stage,
// plus the registered ID/EX latch outputs.
interface id_operand_stage_if #(
  parameter int DATA_W = 32,
  parameter int NREG   = 32,
  parameter int NRD    = 2,
  parameter int CNT_W  = 16
);
  localparam int AW = $clog2(NREG);

  logic                  id_valid;
  logic [DATA_W-1:0]     id_pc;
  logic [NRD*AW-1:0]     id_src;
  logic [NRD-1:0]        id_use;
  logic [AW-1:0]         id_dst;
  logic                  id_wen;
  logic                  id_load;
  logic                  id_link;

  logic [AW-1:0]         ex_rd;
  logic                  ex_wen;
  logic                  ex_load;
  logic [DATA_W-1:0]     ex_alu;

  logic [AW-1:0]         mem_rd;
  logic                  mem_wen;
  logic                  mem_load;
  logic [DATA_W-1:0]     mem_alu;
  logic [DATA_W-1:0]     mem_rdata;
  logic                  mem_rdata_vld;

  logic [AW-1:0]         wb_rd;
  logic                  wb_wen;
  logic [DATA_W-1:0]     wb_data;

  logic                  ex_flush;

  logic                  stall;
  logic [NRD*DATA_W-1:0] opnd_q;
  logic                  vld_q;
  logic [AW-1:0]         dst_q;
  logic                  wen_q;
  logic                  load_q;
  logic [1:0]            cause_q;
  logic [CNT_W-1:0]      stall_cnt;

  modport master (
    output id_valid, id_pc, id_src, id_use, id_dst, id_wen, id_load, id_link,
    output ex_rd, ex_wen, ex_load, ex_alu,
    output mem_rd, mem_wen, mem_load, mem_alu, mem_rdata, mem_rdata_vld,
    output wb_rd, wb_wen, wb_data, ex_flush,
    input  stall, opnd_q, vld_q, dst_q, wen_q, load_q, cause_q, stall_cnt
  );

  modport slave (
    input  id_valid, id_pc, id_src, id_use, id_dst, id_wen, id_load, id_link,
    input  ex_rd, ex_wen, ex_load, ex_alu,
    input  mem_rd, mem_wen, mem_load, mem_alu, mem_rdata, mem_rdata_vld,
    input  wb_rd, wb_wen, wb_data, ex_flush,
    output stall, opnd_q, vld_q, dst_q, wen_q, load_q, cause_q, stall_cnt
  );

endinterface

// File: rtl/id_operand_stage_regfile_np.sv
// Architectural register file: NRD asynchronous read ports, one synchronous
// write port, r0 hard-wired to zero.
module regfile_np #(
  parameter int DATA_W = 32,
  parameter int NREG   = 32,
  parameter int NRD    = 2,
  parameter int AW     = $clog2(NREG)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wen,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [NRD*AW-1:0]     raddr,
  output logic [NRD*DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [NREG];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < NREG; r++) mem[r] <= '0;
    end else if (wen && waddr != '0) begin
      mem[waddr] <= wdata;
    end
  end

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0] ra;
    assign ra = raddr[i*AW +: AW];
    assign rdata[i*DATA_W +: DATA_W] = (ra == '0) ? '0 : mem[ra];
  end

endmodule

// File: rtl/id_operand_stage.sv
// ID operand stage: register file read with EX/MEM/WB forwarding, load-use and
// load-data-wait stall generation, and the registered ID/EX operand latch.
module id_operand_stage
  import id_operand_stage_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int NREG   = 32,
  parameter int NRD    = 2,
  parameter int CNT_W  = 16
) (
  input  logic               clk,
  input  logic               reset,
  id_operand_stage_if.slave  bus
);

  localparam int AW = $clog2(NREG);

  logic [NRD*DATA_W-1:0] rf_rdata;
  logic [NRD*DATA_W-1:0] fwd_data;
  logic [NRD*DATA_W-1:0] opnd_d;
  logic [NRD-1:0]        lu_hit;
  logic [NRD-1:0]        mw_hit;
  logic [AW-1:0]         dst_d;
  logic                  wen_d;
  logic                  bubble;
  cause_e                cause_d;

  regfile_np #(
    .DATA_W (DATA_W),
    .NREG   (NREG),
    .NRD    (NRD),
    .AW     (AW)
  ) u_regfile (
    .clk   (clk),
    .reset (reset),
    .wen   (bus.wb_wen),
    .waddr (bus.wb_rd),
    .wdata (bus.wb_data),
    .raddr (bus.id_src),
    .rdata (rf_rdata)
  );

  for (genvar i = 0; i < NRD; i++) begin : g_port
    logic [AW-1:0]     src;
    logic              chk;
    logic [DATA_W-1:0] sel;

    assign src = bus.id_src[i*AW +: AW];
    assign chk = bus.id_valid && !bus.id_link && bus.id_use[i] && (src != '0);

    assign lu_hit[i] = chk && bus.ex_load && bus.ex_wen && (bus.ex_rd == src);
    assign mw_hit[i] = chk && bus.mem_load && bus.mem_wen && (bus.mem_rd == src)
                       && !bus.mem_rdata_vld;

    // A load in EX has no data yet, so it is skipped and the hazard stalls instead
    always_comb begin
      sel = rf_rdata[i*DATA_W +: DATA_W];
      if (src == '0) begin
        sel = '0;
      end else if (bus.ex_wen && bus.ex_rd == src && !bus.ex_load) begin
        sel = bus.ex_alu;
      end else if (bus.mem_wen && bus.mem_rd == src) begin
        sel = bus.mem_load ? bus.mem_rdata : bus.mem_alu;
      end else if (bus.wb_wen && bus.wb_rd == src) begin
        sel = bus.wb_data;
      end
    end

    assign fwd_data[i*DATA_W +: DATA_W] = sel;
  end

  assign bus.stall = (|lu_hit) || (|mw_hit);

  always_comb begin
    cause_d = CAUSE_RUN;
    if (|lu_hit) begin
      cause_d = CAUSE_LU_STALL;
    end else if (|mw_hit) begin
      cause_d = CAUSE_MEM_WAIT;
    end
  end

  always_comb begin
    opnd_d = fwd_data;
    dst_d  = bus.id_dst;
    wen_d  = bus.id_wen;
    if (bus.id_link) begin
      opnd_d             = '0;
      opnd_d[DATA_W-1:0] = bus.id_pc + DATA_W'(LINK_OFFSET);
      dst_d              = AW'(NREG - 1);
      wen_d              = 1'b1;
    end
  end

  assign bubble = bus.ex_flush || bus.stall || !bus.id_valid;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.opnd_q <= '0;
      bus.vld_q  <= 1'b0;
      bus.dst_q  <= '0;
      bus.wen_q  <= 1'b0;
      bus.load_q <= 1'b0;
    end else if (bubble) begin
      bus.opnd_q <= '0;
      bus.vld_q  <= 1'b0;
      bus.dst_q  <= '0;
      bus.wen_q  <= 1'b0;
      bus.load_q <= 1'b0;
    end else begin
      bus.opnd_q <= opnd_d;
      bus.vld_q  <= 1'b1;
      bus.dst_q  <= dst_d;
      bus.wen_q  <= wen_d;
      bus.load_q <= bus.id_load;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.cause_q   <= 2'd0;
      bus.stall_cnt <= '0;
    end else begin
      bus.cause_q <= cause_d;
      if (bus.stall && bus.stall_cnt != '1) begin
        bus.stall_cnt <= bus.stall_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_id_operand_stage.sv
// Scoreboard bench for id_operand_stage: the driver queues the expected ID/EX
// latch contents for each cycle and a monitor compares them after each edge.
module tb_id_operand_stage;

  localparam int DATA_W = 32;
  localparam int NREG   = 32;
  localparam int NRD    = 2;
  localparam int CNT_W  = 4;

  typedef struct packed {
    logic        vld;
    logic [4:0]  dst;
    logic        wen;
    logic        load;
    logic [31:0] op0;
    logic [31:0] op1;
    logic [1:0]  cause;
    logic [3:0]  cnt;
  } exp_t;

  logic clk;
  logic reset;
  int   total;
  int   bad;
  logic [3:0] exp_cnt;
  exp_t  exp_q [$];
  string name_q [$];

  id_operand_stage_if #(.DATA_W(DATA_W), .NREG(NREG), .NRD(NRD), .CNT_W(CNT_W)) bus ();

  id_operand_stage #(.DATA_W(DATA_W), .NREG(NREG), .NRD(NRD), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic vld, input logic [4:0] dst, input logic wen,
                              input logic load, input logic [31:0] op0,
                              input logic [31:0] op1, input logic [1:0] cause);
    exp_t e;
    e.vld = vld; e.dst = dst; e.wen = wen; e.load = load;
    e.op0 = op0; e.op1 = op1; e.cause = cause; e.cnt = 4'd0;
    return e;
  endfunction

  function automatic exp_t bub(input logic [1:0] cause);
    return mk(1'b0, 5'd0, 1'b0, 1'b0, 32'd0, 32'd0, cause);
  endfunction

  task automatic clear_in();
    bus.id_valid = 0; bus.id_pc = '0; bus.id_src = '0; bus.id_use = '0;
    bus.id_dst = '0; bus.id_wen = 0; bus.id_load = 0; bus.id_link = 0;
    bus.ex_rd = '0; bus.ex_wen = 0; bus.ex_load = 0; bus.ex_alu = '0;
    bus.mem_rd = '0; bus.mem_wen = 0; bus.mem_load = 0; bus.mem_alu = '0;
    bus.mem_rdata = '0; bus.mem_rdata_vld = 0;
    bus.wb_rd = '0; bus.wb_wen = 0; bus.wb_data = '0; bus.ex_flush = 0;
  endtask

  task automatic set_id(input logic [31:0] pc, input logic [4:0] s0, input logic [4:0] s1,
                        input logic [1:0] use_b, input logic [4:0] dst, input logic wen,
                        input logic load, input logic link);
    bus.id_valid = 1; bus.id_pc = pc; bus.id_src = {s1, s0}; bus.id_use = use_b;
    bus.id_dst = dst; bus.id_wen = wen; bus.id_load = load; bus.id_link = link;
  endtask

  // Inputs are already applied; check stall, queue the latch result, cross one edge
  task automatic step(input string nm, input logic exp_stall, input exp_t e_in);
    exp_t e;
    e = e_in;
    #1;
    chk({nm, ".stall"}, {31'd0, bus.stall}, {31'd0, exp_stall});
    if (exp_stall && exp_cnt != 4'hF) exp_cnt = exp_cnt + 4'd1;
    e.cnt = exp_cnt;
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge clk);
    #2;
  endtask

  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      exp_t  e;
      string nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      chk({nm, ".vld"},   {31'd0, bus.vld_q},     {31'd0, e.vld});
      chk({nm, ".dst"},   {27'd0, bus.dst_q},     {27'd0, e.dst});
      chk({nm, ".wen"},   {31'd0, bus.wen_q},     {31'd0, e.wen});
      chk({nm, ".load"},  {31'd0, bus.load_q},    {31'd0, e.load});
      chk({nm, ".op0"},   bus.opnd_q[31:0],       e.op0);
      chk({nm, ".op1"},   bus.opnd_q[63:32],      e.op1);
      chk({nm, ".cause"}, {30'd0, bus.cause_q},   {30'd0, e.cause});
      chk({nm, ".cnt"},   {28'd0, bus.stall_cnt}, {28'd0, e.cnt});
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    total = 0; bad = 0; exp_cnt = 4'd0;
    clear_in();
    reset = 1'b0;
    #22;
    chk("rst.opnd",  bus.opnd_q[31:0] | bus.opnd_q[63:32], 32'd0);
    chk("rst.vld",   {31'd0, bus.vld_q},     32'd0);
    chk("rst.cause", {30'd0, bus.cause_q},   32'd0);
    chk("rst.cnt",   {28'd0, bus.stall_cnt}, 32'd0);
    reset = 1'b1;

    // Regfile write then later read, and same-cycle WB bypass
    clear_in(); bus.wb_wen = 1; bus.wb_rd = 5; bus.wb_data = 32'h1234;
    step("wb_wr", 0, bub(0));
    clear_in();
    step("idle", 0, bub(0));
    set_id(32'h0, 5'd0, 5'd5, 2'b11, 5'd7, 1, 0, 0);
    step("rd_r5", 0, mk(1, 5'd7, 1, 0, 32'd0, 32'h1234, 0));
    clear_in(); bus.wb_wen = 1; bus.wb_rd = 9; bus.wb_data = 32'hBEEF;
    set_id(32'h0, 5'd9, 5'd5, 2'b11, 5'd2, 1, 1, 0);
    step("wb_byp", 0, mk(1, 5'd2, 1, 1, 32'hBEEF, 32'h1234, 0));

    // EX over MEM priority, then MEM when EX does not write
    clear_in();
    bus.ex_wen = 1; bus.ex_rd = 3; bus.ex_alu = 32'hA;
    bus.mem_wen = 1; bus.mem_rd = 3; bus.mem_alu = 32'hB;
    set_id(32'h0, 5'd3, 5'd0, 2'b01, 5'd1, 1, 0, 0);
    step("ex_pri", 0, mk(1, 5'd1, 1, 0, 32'hA, 32'd0, 0));
    bus.ex_wen = 0; bus.id_src = {5'd3, 5'd3};
    step("mem_fwd", 0, mk(1, 5'd1, 1, 0, 32'hB, 32'hB, 0));

    // Load-use: one stall, then data forwarded from MEM
    clear_in();
    bus.ex_load = 1; bus.ex_wen = 1; bus.ex_rd = 4;
    set_id(32'h0, 5'd4, 5'd0, 2'b01, 5'd8, 1, 0, 0);
    step("lu_stall", 1, bub(1));
    bus.ex_load = 0; bus.ex_wen = 0; bus.ex_rd = 0;
    bus.mem_load = 1; bus.mem_wen = 1; bus.mem_rd = 4;
    bus.mem_rdata = 32'h77; bus.mem_rdata_vld = 1;
    step("lu_mem", 0, mk(1, 5'd8, 1, 0, 32'h77, 32'd0, 0));

    // Load data not yet valid: stall for each waiting cycle
    clear_in();
    bus.mem_load = 1; bus.mem_wen = 1; bus.mem_rd = 6; bus.mem_rdata_vld = 0;
    set_id(32'h0, 5'd0, 5'd6, 2'b10, 5'd10, 1, 0, 0);
    for (int k = 0; k < 3; k++) step("mw_wait", 1, bub(2));
    bus.mem_rdata_vld = 1; bus.mem_rdata = 32'h66;
    step("mw_done", 0, mk(1, 5'd10, 1, 0, 32'd0, 32'h66, 0));
    bus.mem_rdata_vld = 0; bus.mem_rdata = 32'h55; bus.id_use = 2'b00;
    step("no_use", 0, mk(1, 5'd10, 1, 0, 32'd0, 32'h55, 0));

    // jal link value, then the same cycle flushed
    clear_in();
    bus.ex_load = 1; bus.ex_wen = 1; bus.ex_rd = 4;
    set_id(32'h400, 5'd4, 5'd6, 2'b11, 5'd3, 0, 0, 1);
    step("link", 0, mk(1, 5'd31, 1, 0, 32'h408, 32'd0, 0));
    bus.ex_flush = 1;
    step("link_flush", 0, bub(0));

    // r0 is never forwarded and never hazards
    clear_in();
    bus.ex_wen = 1; bus.ex_load = 1; bus.ex_rd = 0; bus.ex_alu = 32'hDEAD;
    bus.wb_wen = 1; bus.wb_rd = 0; bus.wb_data = 32'h99;
    set_id(32'h0, 5'd0, 5'd5, 2'b11, 5'd12, 1, 0, 0);
    step("r0", 0, mk(1, 5'd12, 1, 0, 32'd0, 32'h1234, 0));

    // Flush with a stall keeps stall up; invalid ID never stalls
    clear_in();
    bus.ex_load = 1; bus.ex_wen = 1; bus.ex_rd = 4; bus.ex_flush = 1;
    set_id(32'h0, 5'd4, 5'd0, 2'b01, 5'd8, 1, 0, 0);
    step("flush_stall", 1, bub(1));
    bus.ex_flush = 0; bus.id_valid = 0;
    step("invalid", 0, bub(0));

    // Counter saturation at all-ones
    bus.id_valid = 1;
    for (int k = 0; k < 14; k++) step("sat", 1, bub(1));

    // Reset asserted mid-stall clears everything, regfile included
    #1;
    reset = 1'b0;
    #1;
    chk("rst2.cnt",   {28'd0, bus.stall_cnt}, 32'd0);
    chk("rst2.cause", {30'd0, bus.cause_q},   32'd0);
    @(posedge clk);
    #2;
    reset = 1'b1;
    exp_cnt = 4'd0;
    clear_in();
    set_id(32'h0, 5'd0, 5'd5, 2'b11, 5'd6, 1, 0, 0);
    step("post_rst", 0, mk(1, 5'd6, 1, 0, 32'd0, 32'd0, 0));

    clear_in();
    repeat (3) @(posedge clk);
    #3;
    chk("queue_empty", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/id_operand_stage.md
# id_operand_stage

Parametrised instruction-decode operand stage for the five-stage MIPS pipeline. It contains the architectural register file, EX/MEM/WB forwarding for any number of read ports, and load-use and load-data-wait stall generation. It also holds the registered ID/EX operand latch, with jal link-value generation and a stall performance counter. It sits between the IF/ID latch and the EX stage; decode control stays outside.

## Interface
Parameters:
- DATA_W, 32, datapath width
- NREG, 32, number of architectural registers (AW = clog2(NREG))
- NRD, 2, number of read ports
- CNT_W, 16, width of stall counter

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- id_valid  in  1  ID holds a real instruction
- id_pc  in  DATA_W  PC of ID instruction
- id_src  in  NRD*AW  source indices, port i at [i*AW +: AW]
- id_use  in  NRD  port i actually reads its source
- id_dst, id_wen, id_load  in  AW/1/1  destination, writes-reg, is-load
- id_link  in  1  jal: link mode
- ex_rd, ex_wen, ex_load, ex_alu  in  AW/1/1/DATA_W  EX-stage producer
- mem_rd, mem_wen, mem_load, mem_alu, mem_rdata, mem_rdata_vld  in  AW/1/1/DATA_W/DATA_W/1  MEM-stage producer
- wb_rd, wb_wen, wb_data  in  AW/1/DATA_W  write-back port
- ex_flush  in  1  squash the ID/EX latch this cycle
- stall  out  1  combinational; hold PC and IF/ID
- opnd_q  out  NRD*DATA_W  registered operands
- vld_q, dst_q, wen_q, load_q  out  1/AW/1/1  registered ID/EX control
- cause_q  out  2  registered stall cause: 0 RUN, 1 LU_STALL, 2 MEM_WAIT
- stall_cnt  out  CNT_W  saturating count of stall cycles

## Operation
- Register 0 reads 0 and is never written or forwarded.
- Register file write: on a clk edge with wb_wen && wb_rd != 0.
- Source select for port i (src = id_src[i]), first match wins:
  1. EX: ex_wen && ex_rd == src && !ex_load, select ex_alu.
  2. MEM: mem_wen && mem_rd == src, select mem_load ? mem_rdata : mem_alu.
  3. WB: wb_wen && wb_rd == src, select wb_data (same-cycle bypass).
  4. Otherwise the register file.
- Hazards are evaluated only when id_valid && !id_link && id_use[i] && src != 0.
  - LU_STALL: ex_load && ex_wen && ex_rd == src.
  - MEM_WAIT: mem_load && mem_wen && mem_rd == src && !mem_rdata_vld.
  - LU_STALL has priority over MEM_WAIT for cause_q.
- stall = any hazard on any port.
- Link mode (id_link): operand 0 = id_pc + 8 (mod 2^DATA_W), all other operands 0, dst = NREG-1, wen = 1, no hazard check.
- ID/EX latch update at each edge:
  - ex_flush, stall, or !id_valid: load a bubble (vld_q = 0, wen_q = 0, load_q = 0, opnd_q and dst_q = 0).
  - Otherwise: capture the selected operands and id_dst/id_wen/id_load (link overrides apply).
  - ex_flush together with stall: bubble, and stall stays asserted.
- cause_q registers the current stall cause every cycle (0 when no stall).
- stall_cnt increments on every cycle with stall = 1 and saturates at all-ones.

## Timing
- Reset (reset = 0, async): all regfile entries 0, opnd_q 0, vld_q/wen_q/load_q 0, dst_q 0, cause_q 0, stall_cnt 0.
- Reset release mid-stall: the first edge after release evaluates fresh inputs; no stall history is kept.
- Operand latency: 1 cycle from ID inputs to opnd_q.
- stall is combinational in the same cycle as the hazard.
- Load-use costs exactly 1 stall cycle. On the next cycle the load sits in MEM and data comes from mem_rdata.
- MEM_WAIT holds stall for as many cycles as mem_rdata_vld = 0.
- A write and a read of the same register in one cycle return the new value (bypass).

## Structure
- Shared package: the stall-cause encodings (RUN/LU_STALL/MEM_WAIT) and a link-offset constant of 8.
- One sub-module, regfile_np (NREG x DATA_W, NRD async read ports, one synchronous write port, r0 = 0, async active-low clear). Forwarding muxes, hazard logic and the latch live in the top.

## Test plan
- Write r5 = 0x1234 via WB, then read r5 on port 1 two cycles later: opnd_q[1] = 0x1234. WB write and ID read of r5 in the same cycle: the same value via bypass.
- ex_alu = 0xA, ex_rd = 3 and mem_alu = 0xB, mem_rd = 3; ID reads r3: opnd_q = 0xA (EX priority). With ex_wen = 0: opnd_q = 0xB.
- ex_load = 1, ex_rd = 4; ID uses r4: stall = 1 for one cycle, bubble latched, cause_q = 1. Next cycle mem_load, mem_rdata = 0x77: opnd_q = 0x77, stall_cnt = 1.
- mem_load, mem_rd = 6, mem_rdata_vld = 0 for 3 cycles: stall for 3 cycles, cause_q = 2, stall_cnt = 3, then the operand is captured.
- id_link, id_pc = 0x400: opnd_q[0] = 0x408, opnd_q[1] = 0, dst_q = 31, wen_q = 1. The same cycle with ex_flush = 1: vld_q = 0.
- ID reads r0 while ex_rd = 0, ex_wen = 1: operand 0 and no stall. Force a stall with stall_cnt at all-ones: the counter holds.
